alu_result_buffer: RTL and testbench
====================================

// Module: alu_result_buffer
// PURPOSE
//  Downstream stage of the 6-bit ALU. Captures each ALU result and its flag set
//  (R, GT_ZERO, SF, CF, ZF) over a valid/ready handshake into a small FIFO.
//  Accumulates sticky status flags across results and checks that the ALU's
//  flags are consistent with R. Feeds writeback and the status register.
// PARAMETERS
//  DATA_W  6  width of ALU result R
//  DEPTH   4  FIFO entries; power of two, >=2
//  PTR_W   2  log2(DEPTH)
// PORTS
//  clk           in   1        rising-edge clock; single clock domain
//  rst_n         in   1        asynchronous, active-low reset
//  in_valid      in   1        ALU result presented this cycle
//  in_ready      out  1        buffer can accept; = !full
//  in_r          in   DATA_W   ALU result R
//  in_gt_zero    in   1        ALU GT_ZERO
//  in_sf         in   1        ALU sign flag
//  in_cf         in   1        ALU carry flag
//  in_zf         in   1        ALU zero flag
//  out_valid     out  1        head entry available; = !empty
//  out_ready     in   1        consumer takes head entry
//  out_r         out  DATA_W   head entry result
//  out_flags     out  4        head entry flags {GT_ZERO,SF,CF,ZF}
//  count         out  PTR_W+1  entries held, 0..DEPTH
//  sticky_flags  out  4        OR of {GT_ZERO,SF,CF,ZF} over all pushes since clear
//  sticky_clr    in   1        synchronous clear of sticky_flags and flag_err
//  flag_err      out  1        sticky: an accepted entry had inconsistent flags
//  res_cnt       out  8        accepted results since reset, wraps 255->0
// BEHAVIOUR
//  - Reset (rst_n=0, async): wr/rd pointers=0, count=0, out_valid=0, in_ready=1,
//    sticky_flags=0, flag_err=0, res_cnt=0. out_r/out_flags=0 while empty.
//    Reset mid-operation discards all stored entries immediately.
//  - Push = in_valid & in_ready; pop = out_valid & out_ready. Both on clk edge.
//  - Storage: DEPTH x (DATA_W+4) registers; out_r/out_flags driven from the head
//    register (show-ahead). No bypass: a push into an empty buffer at edge N
//    gives out_valid=1 with that entry after edge N (1-cycle latency).
//  - Full (count=DEPTH): in_ready=0; push is blocked even if pop occurs the same
//    cycle (no full-pass-through). Upstream holds in_valid and data stable.
//  - Empty: out_valid=0; out_ready ignored; no pointer movement.
//  - Simultaneous push and pop, 0<count<DEPTH: both pointers advance, count
//    unchanged, FIFO order preserved.
//  - Pointers wrap DEPTH-1 -> 0; count uses PTR_W+1 bits to distinguish full.
//  - Sticky: on push, sticky_flags <= sticky_flags | pushed flags. sticky_clr
//    with no push -> 0. sticky_clr with push in same cycle -> pushed flags
//    only (clear takes effect first).
//  - Consistency check on each accepted push; error if any of:
//    in_zf != (in_r==0); in_sf != in_r[DATA_W-1];
//    in_gt_zero != (!in_sf & !in_zf). in_cf not checked.
//    Error sets flag_err next edge; flag_err held until sticky_clr (clr with an
//    erroneous push in same cycle -> flag_err=1). Entry is stored regardless.
//  - res_cnt increments on every push, 8-bit wrap, cleared only by reset.
//  - No X propagation: unread storage never reaches out_* while out_valid=0.
// TESTING
//  1 Push R=011001, flags 1000, out_ready=0 -> next cycle out_valid=1,
//    out_r=011001, out_flags=1000, count=1, res_cnt=1, flag_err=0.
//  2 out_ready=0, push 5 consecutive results -> count=4, in_ready=0, 5th held;
//    one pop -> 5th accepted next edge, count back to 4, order 1..5 on drain.
//  3 count=2, push and pop in same cycle for 3 cycles -> count stays 2, outputs
//    appear in push order, pointers wrap correctly past DEPTH-1.
//  4 Push R=000000 with ZF=0 -> flag_err=1 next cycle; push R=100000, SF=1,
//    GT=0, ZF=0 -> flag_err stays 1; sticky_clr -> flag_err=0.
//  5 Push CF=1 (sticky=0010), then sticky_clr with push of R=0 flags 0001 ->
//    sticky_flags=0001; sticky_clr alone -> 0000.
//  6 count=3, assert rst_n=0 mid-cycle -> count=0, out_valid=0, in_ready=1,
//    sticky_flags=0, res_cnt=0 without waiting for clk; 256 pushes -> res_cnt=0.

Source files
------------

// File: rtl/alu_result_buffer.sv
// Result/flag FIFO behind the 6-bit ALU: show-ahead storage, sticky status
// accumulation and a per-push check that the ALU flags agree with R.
module alu_result_buffer #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_r,
    input  logic              in_gt_zero,
    input  logic              in_sf,
    input  logic              in_cf,
    input  logic              in_zf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_r,
    output logic [3:0]        out_flags,
    output logic [PTR_W:0]    count,
    output logic [3:0]        sticky_flags,
    input  logic              sticky_clr,
    output logic              flag_err,
    output logic [7:0]        res_cnt
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_r     [DEPTH];
    logic [3:0]        mem_flags [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [3:0]        in_flags;
    logic              push;
    logic              pop;
    logic              bad;

    function automatic logic flags_bad(input logic [DATA_W-1:0] r,
                                       input logic gt, input logic sf,
                                       input logic zf);
        logic zf_exp;
        logic gt_exp;
        zf_exp = (r == '0);
        gt_exp = !sf && !zf;
        return (zf != zf_exp) || (sf != r[DATA_W-1]) || (gt != gt_exp);
    endfunction

    assign in_flags  = {in_gt_zero, in_sf, in_cf, in_zf};
    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign bad       = flags_bad(in_r, in_gt_zero, in_sf, in_zf);

    // Gate the head so unwritten storage is never visible while empty
    assign out_r     = out_valid ? mem_r[rd_ptr]     : '0;
    assign out_flags = out_valid ? mem_flags[rd_ptr] : '0;

    // Data storage carries no reset; control below decides what is visible
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr]     <= in_r;
            mem_flags[wr_ptr] <= in_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            sticky_flags <= '0;
            flag_err     <= 1'b0;
            res_cnt      <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                res_cnt <= res_cnt + 8'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Clear is applied before this cycle's push contribution
            if (sticky_clr) begin
                sticky_flags <= push ? in_flags : 4'b0000;
                flag_err     <= push && bad;
            end else if (push) begin
                sticky_flags <= sticky_flags | in_flags;
                if (bad) begin
                    flag_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Scoreboard bench for alu_result_buffer: a queue model tracks contents,
// sticky flags, error flag and result count, checked every cycle.
module tb_alu_result_buffer;

    localparam int DATA_W = 6;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_r;
    logic              in_gt_zero;
    logic              in_sf;
    logic              in_cf;
    logic              in_zf;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_r;
    logic [3:0]        out_flags;
    logic [PTR_W:0]    count;
    logic [3:0]        sticky_flags;
    logic              sticky_clr;
    logic              flag_err;
    logic [7:0]        res_cnt;

    alu_result_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_gt_zero(in_gt_zero), .in_sf(in_sf), .in_cf(in_cf),
        .in_zf(in_zf), .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_flags(out_flags), .count(count),
        .sticky_flags(sticky_flags), .sticky_clr(sticky_clr),
        .flag_err(flag_err), .res_cnt(res_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    logic [9:0] q[$];
    logic [3:0] m_sticky;
    logic       m_err;
    logic [7:0] m_res;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic m_bad(input logic [5:0] r, input logic [3:0] f);
        logic zero_r;
        zero_r = (r == 6'd0);
        if (f[0] != zero_r) return 1'b1;
        if (f[2] != r[5]) return 1'b1;
        if (f[3] != (!f[2] && !f[0])) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] good_flags(input logic [5:0] r, input logic cf);
        logic z;
        z = (r == 6'd0);
        return {!r[5] && !z, r[5], cf, z};
    endfunction

    task automatic drive(input logic v, input logic [5:0] r, input logic [3:0] f,
                         input logic ordy, input logic clr);
        in_valid   = v;
        in_r       = r;
        {in_gt_zero, in_sf, in_cf, in_zf} = f;
        out_ready  = ordy;
        sticky_clr = clr;
    endtask

    task automatic check_state();
        chk("count", 32'(count), 32'(q.size()));
        chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("sticky", 32'(sticky_flags), 32'(m_sticky));
        chk("flag_err", 32'(flag_err), 32'(m_err));
        chk("res_cnt", 32'(res_cnt), 32'(m_res));
        if (q.size() == 0) begin
            chk("out_r_empty", 32'(out_r), 32'd0);
            chk("out_flags_empty", 32'(out_flags), 32'd0);
        end else begin
            chk("head_r", 32'(out_r), 32'(q[0][9:4]));
            chk("head_flags", 32'(out_flags), 32'(q[0][3:0]));
        end
    endtask

    // Called just after a falling edge with inputs already driven
    task automatic step();
        logic       push;
        logic       pop;
        logic [3:0] f;
        logic [9:0] e;
        f    = {in_gt_zero, in_sf, in_cf, in_zf};
        push = in_valid && (q.size() < DEPTH);
        pop  = out_ready && (q.size() > 0);
        if (pop) begin
            e = q.pop_front();
            chk("pop_r", 32'(out_r), 32'(e[9:4]));
            chk("pop_flags", 32'(out_flags), 32'(e[3:0]));
        end
        if (sticky_clr) begin
            m_sticky = push ? f : 4'b0000;
            m_err    = push && m_bad(in_r, f);
        end else if (push) begin
            m_sticky = m_sticky | f;
            if (m_bad(in_r, f)) m_err = 1'b1;
        end
        if (push) begin
            q.push_back({in_r, f});
            m_res = m_res + 8'd1;
        end
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) begin
            drive(1'b0, 6'd0, 4'd0, 1'b1, 1'b0);
            step();
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_sticky = 4'd0;
        m_err    = 1'b0;
        m_res    = 8'd0;
    endtask

    initial begin
        logic [5:0] r;
        rst_n = 1'b0;
        drive(1'b0, 6'd0, 4'd0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_state();
        rst_n = 1'b1;

        // 1: single push, show-ahead after one edge
        drive(1'b1, 6'b011001, 4'b1000, 1'b0, 1'b0);
        step();
        drive(1'b0, 6'd0, 4'd0, 1'b0, 1'b0);
        step();
        drain();

        // 2: fill past full, held 5th result, then drain in order
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 6'(i), good_flags(6'(i), 1'b0), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 6'd5, good_flags(6'd5, 1'b0), 1'b1, 1'b0);
        step();
        drive(1'b1, 6'd5, good_flags(6'd5, 1'b0), 1'b0, 1'b0);
        step();
        drain();

        // 3: steady push+pop at count 2, pointers wrap
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 6'(40 + i), good_flags(6'(40 + i), 1'b1), 1'b0, 1'b0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 6'(50 + i), good_flags(6'(50 + i), 1'b0), 1'b1, 1'b0);
            step();
        end
        drain();

        // 4: inconsistent flags latch flag_err until cleared
        drive(1'b1, 6'b000000, 4'b0000, 1'b1, 1'b0);
        step();
        drive(1'b1, 6'b100000, 4'b0100, 1'b1, 1'b0);
        step();
        drive(1'b0, 6'd0, 4'd0, 1'b1, 1'b1);
        step();
        drain();

        // 5: sticky clear ordering against same-cycle push
        drive(1'b1, 6'b000001, 4'b0010, 1'b1, 1'b1);
        step();
        drive(1'b1, 6'b000000, 4'b0001, 1'b1, 1'b1);
        step();
        drive(1'b0, 6'd0, 4'd0, 1'b1, 1'b1);
        step();
        drain();

        // 6: asynchronous reset mid-cycle with three entries held
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 6'(i + 9), 4'b1111, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 6'd0, 4'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_state();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            r = 6'($urandom_range(0, 63));
            drive(1'b1, r, good_flags(r, 1'($urandom_range(0, 1))), 1'b1, 1'b0);
            step();
        end
        drain();

        // Random mix of traffic, clears and flag patterns
        for (int i = 0; i < 300; i++) begin
            r = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0)
                drive(1'($urandom_range(0, 1)), r, 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
            else
                drive(1'($urandom_range(0, 1)), r, good_flags(r, 1'($urandom_range(0, 1))),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
            step();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
